uart_ram_loader: RTL

Serial loader that receives a framed byte stream on a UART RX pin and writes 16-bit words into the data RAM's CPU-side port. It is the writer counterpart to the screen-read path: it fills the RAM that the VGA path displays, with no CPU program needed. It sits beside `cpu` in `top`. Its `busy` output holds the CPU in reset and selects the loader onto the RAM `addr`/`wdata`/`we` mux.

---
 rtl/uart_ram_loader_pkg.sv | 42 ++++
 rtl/uart_ram_loader_rx.sv | 107 ++++++++++
 rtl/uart_ram_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ram_loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
//   Shared types and constants for the UART RAM loader.
//   - loader_state_t : frame-parser FSM states (top level)
//   - rx_state_t     : byte receiver FSM states (uart_rx_byte)
//   - SYNC_BYTE      : frame start marker
//   - clks_per_bit() : bit period in clock cycles, truncated
//   Optional feature macro: UART_RAM_LOADER_CHECKSUM_EN adds the CHECK state.
// -----------------------------------------------------------------------------
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // ST_FINISH is a one-cycle tail after the final write so that done lands
  // on the cycle after that write's we pulse.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_FINISH
`ifdef UART_RAM_LOADER_CHECKSUM_EN
    ,
    ST_CHECK
`endif
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_ram_loader_rx.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART byte receiver, LSB first, line idle high.
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     rx         in   serial line, asynchronous to clk
//     byte_valid out  one-cycle pulse, byte_data holds a good byte
//     byte_data  out  last received byte
//     frame_err  out  one-cycle pulse when the stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        // Edge rather than level: a line left low after a bad stop bit must
        // not be mistaken for a fresh start bit.
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          // Still low at mid-bit means a real start bit; otherwise a glitch.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) valid_d = 1'b1;
          else         ferr_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_ram_loader.sv
// -----------------------------------------------------------------------------
// uart_ram_loader
//   Receives framed bytes on a UART line and writes 16-bit words into the
//   CPU-side RAM port. Frame: A5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO,
//   CNT words (MSB byte first), then CHK when checksumming is built.
//   Ports:
//     CLK_50   in   system clock
//     resetN   in   asynchronous active-low reset
//     uart_rx  in   serial line, idle high, 8N1
//     addr     out  RAM write address (advances the cycle after each write)
//     wdata    out  RAM write data
//     we       out  one-cycle write strobe per word
//     busy     out  frame in progress (holds the CPU off the RAM port)
//     done     out  one-cycle pulse, frame completed
//     err      out  one-cycle pulse, frame aborted or checksum mismatch
//   Optional feature macro: UART_RAM_LOADER_CHECKSUM_EN -- expect a trailing
//   modulo-256 sum of the data bytes; a mismatch reports err instead of done.
// -----------------------------------------------------------------------------
module uart_ram_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200
) (
  input  logic                  CLK_50,
  input  logic                  resetN,
  input  logic                  uart_rx,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (CLK_50),
    .rst_n     (resetN),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  loader_state_t         state_q, state_d;
  logic [7:0]            addr_hi_q, addr_hi_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            data_hi_q, data_hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      addr_hi_q <= '0;
      cnt_q     <= '0;
      data_hi_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_hi_q <= addr_hi_d;
      cnt_q     <= cnt_d;
      data_hi_q <= data_hi_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    cnt_d     = cnt_q;
    data_hi_d = data_hi_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
    chk_d     = chk_q;
`endif

    // Post-increment: addr stays on the written location while we is high,
    // then steps (wrapping naturally at 2^ADDR_WIDTH).
    if (we_q) addr_d = addr_q + ADDR_WIDTH'(1);

    case (state_q)
      ST_IDLE: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_d = ST_ADDR_HI;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      ST_ADDR_HI: begin
        if (byte_valid) begin
          addr_hi_d = byte_data;
          state_d   = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (byte_valid) begin
          // Cast keeps only the low ADDR_WIDTH bits of the 16-bit address.
          addr_d  = ADDR_WIDTH'({addr_hi_q, byte_data});
          state_d = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (byte_valid) begin
          cnt_d   = {byte_data, cnt_q[7:0]};
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (byte_valid) begin
          cnt_d = {cnt_q[15:8], byte_data};
          if ({cnt_q[15:8], byte_data} != 16'd0) begin
            state_d = ST_DATA_HI;
          end else begin
`ifdef UART_RAM_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
      ST_DATA_HI: begin
        if (byte_valid) begin
          data_hi_d = byte_data;
          state_d   = ST_DATA_LO;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
          chk_d     = chk_q + byte_data;
`endif
        end
      end
      ST_DATA_LO: begin
        if (byte_valid) begin
          wdata_d = {data_hi_q, byte_data};
          we_d    = 1'b1;
          cnt_d   = cnt_q - 16'd1;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
          chk_d   = chk_q + byte_data;
`endif
          if (cnt_q != 16'd1) begin
            state_d = ST_DATA_HI;
          end else begin
`ifdef UART_RAM_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_FINISH;
`endif
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
`ifdef UART_RAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (byte_valid) begin
          state_d = ST_IDLE;
          if (byte_data == chk_q) done_d = 1'b1;
          else                    err_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A broken byte aborts the frame; a pending half word is discarded,
    // completed writes remain. Noise while idle is not an error.
    if (frame_err && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      we_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign we    = we_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign err   = err_q;

endmodule
